// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the four-square VGA overlay: colors,
//               pattern-entry field positions and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // {R,G,B} color constants
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    // Pattern entry layout: {color[2:0], squares[3:0]}
    localparam int SQ_LSB    = 0;
    localparam int COLOR_LSB = 4;

    // Sequencer state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_counter
// Description : 6-bit frame counter. Counts frame_tick pulses, clears on
//               demand and flags the tick that carries the runtime limit.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [5:0] limit,
    output logic       terminal
);

    logic [5:0] r_count;

    // Count ticks; clear wins so a tick on an entry cycle is not counted
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= 6'd0;
        end else if (tick) begin
            r_count <= r_count + 6'd1;
        end
    end

    // The tick that arrives while the count equals the limit ends the interval
    always_comb begin
        terminal = tick && (r_count == limit);
    end

endmodule : frame_counter
`default_nettype wire

// File: rtl/square_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : square_sequencer
// Description : Playback controller for the four-square VGA overlay. Steps
//               through a programmable pattern, showing each entry for
//               DWELL_FRAMES frames followed by GAP_FRAMES blank frames.
// Revision    : 1.0 - initial release
// ============================================================================
module square_sequencer
    import vga_pkg::*;
#(
    parameter int STEPS        = 8,
    parameter int DWELL_FRAMES = 30,
    parameter int GAP_FRAMES   = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [6:0]               wr_data,
    input  logic [$clog2(STEPS):0]   len,
    input  logic                     start,
    input  logic                     loop,
    input  logic                     abort,
    output logic [3:0]               squares,
    output logic [2:0]               color,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(STEPS)-1:0] step_idx
);

    localparam int               c_AW        = $clog2(STEPS);
    localparam logic [c_AW:0]    c_STEPS_LEN = (c_AW + 1)'(STEPS);
    localparam logic [5:0]       c_DWELL_LIM = 6'(DWELL_FRAMES - 1);
    localparam logic [5:0]       c_GAP_LIM   = (GAP_FRAMES > 0) ? 6'(GAP_FRAMES - 1) : 6'd0;

    logic [6:0]      r_mem [STEPS];
    logic [1:0]      r_state;
    logic [c_AW:0]   r_eff_len;

    logic            w_term;
    logic            w_clear;
    logic            w_last;
    logic [5:0]      w_limit;
    logic [c_AW-1:0] w_step_next;
    logic [6:0]      w_entry_next;
    logic [6:0]      w_entry_first;

    // Pattern memory: written in any state, never cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Counter control: held clear in IDLE and cleared on every state change
    always_comb begin
        w_limit       = (r_state == GAP) ? c_GAP_LIM : c_DWELL_LIM;
        w_clear       = (r_state == IDLE) || w_term || abort;
        w_last        = ({1'b0, step_idx} == (r_eff_len - 1'b1));
        w_step_next   = step_idx + 1'b1;
        w_entry_next  = r_mem[w_step_next];
        w_entry_first = r_mem[0];
    end

    frame_counter u_frame_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .tick     (frame_tick),
        .limit    (w_limit),
        .terminal (w_term)
    );

    // Playback state machine with registered overlay outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_eff_len <= '0;
            squares   <= 4'd0;
            color     <= BLACK;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        r_eff_len <= (len > c_STEPS_LEN) ? c_STEPS_LEN : len;
                        step_idx  <= '0;
                        squares   <= w_entry_first[SQ_LSB +: 4];
                        color     <= w_entry_first[COLOR_LSB +: 3];
                        busy      <= 1'b1;
                        r_state   <= SHOW;
                    end
                end
                SHOW, GAP: begin
                    if (abort) begin
                        squares  <= 4'd0;
                        busy     <= 1'b0;
                        step_idx <= '0;
                        r_state  <= IDLE;
                    end else if (w_term) begin
                        if ((r_state == SHOW) && (GAP_FRAMES > 0)) begin
                            // Blank frames; color keeps its last value
                            squares <= 4'd0;
                            r_state <= GAP;
                        end else if (!w_last) begin
                            step_idx <= w_step_next;
                            squares  <= w_entry_next[SQ_LSB +: 4];
                            color    <= w_entry_next[COLOR_LSB +: 3];
                            r_state  <= SHOW;
                        end else if (loop) begin
                            step_idx <= '0;
                            squares  <= w_entry_first[SQ_LSB +: 4];
                            color    <= w_entry_first[COLOR_LSB +: 3];
                            r_state  <= SHOW;
                        end else begin
                            squares  <= 4'd0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            step_idx <= '0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: begin
                    squares <= 4'd0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : square_sequencer
`default_nettype wire

// File: doc/square_sequencer.md
Name: square_sequencer

Overview:
- Playback controller for the four-square VGA overlay. It drives the squares mask and 3-bit color consumed by the square-drawing logic.
- Plays a programmable pattern of up to STEPS entries. Each step holds one square mask and one color, shown for DWELL_FRAMES frames, then blanked for GAP_FRAMES frames.
- Timebase is a one-cycle frame_tick pulse from the VGA timing generator, so square changes happen once per frame, never mid-frame.

Parameters:
- STEPS, 8, pattern memory depth; power of two, 2..16.
- DWELL_FRAMES, 30, frames each step is visible; 1..63.
- GAP_FRAMES, 10, blank frames after each step; 0..63, 0 = no gap.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse per frame (start of vertical blank)
- wr_en  input  1  pattern memory write strobe
- wr_addr  input  log2(STEPS)  pattern entry index
- wr_data  input  7  {color[2:0], squares[3:0]}
- len  input  log2(STEPS)+1  pattern length in steps, sampled at start
- start  input  1  begin playback (pulse or level)
- loop  input  1  repeat the pattern; sampled at each pattern end
- abort  input  1  stop playback immediately
- squares  output  4  square enable mask to the overlay
- color  output  3  {R,G,B} to the overlay
- busy  output  1  playback active
- done  output  1  one-cycle pulse on normal completion
- step_idx  output  log2(STEPS)  current step index

Behaviour:
- Reset (synchronous, highest priority):
  - squares=0, color=0, busy=0, done=0, step_idx=0, state=IDLE, frame counter=0.
  - Pattern memory contents are not cleared; they are undefined until written.
- Memory writes:
  - A write occurs on any cycle with wr_en=1, in any state.
  - The entry for a step is read only at SHOW entry. A write to the currently displayed step takes effect on the next visit to that step.
- State machine, IDLE / SHOW / GAP; all outputs registered.
  - IDLE: squares=0, busy=0.
    - start=1 and len!=0: latch eff_len = min(len, STEPS); step_idx=0; enter SHOW. From start at cycle T, busy=1 and squares/color = mem[0] at T+1.
    - start=1 and len=0: ignored; no busy, no done.
  - SHOW: squares/color = mem[step_idx], loaded at entry.
    - Frame counter clears at entry and counts frame_tick pulses.
    - The frame_tick carrying count DWELL_FRAMES-1 ends SHOW. The next state is GAP if GAP_FRAMES>0, otherwise the advance rule applies directly.
  - GAP: squares=0, color holds its last value.
    - The frame_tick carrying count GAP_FRAMES-1 applies the advance rule.
  - Advance rule:
    - step_idx < eff_len-1: step_idx+1, enter SHOW.
    - Else with loop=1: step_idx=0, enter SHOW; no done pulse.
    - Else: enter IDLE; squares=0, busy=0, done=1 for exactly one cycle.
- Start handling:
  - A frame_tick in the same cycle as start is not counted; counting begins the cycle after entry.
  - start while busy=1 is ignored; len is not re-sampled.
- abort:
  - abort=1 in SHOW or GAP: next cycle IDLE, squares=0, busy=0, step_idx=0, done=0.
  - abort has priority over start and over the advance rule in the same cycle. abort in IDLE has no effect.
- Counter: 6-bit, never wraps in normal operation; cleared on every state entry.
- eff_len=STEPS is supported: step_idx wraps STEPS-1 -> 0 only through loop.

Decomposition:
- Shared package vga_pkg:
  - Color constants (BLACK=3'b000 … WHITE=3'b111).
  - Pattern-entry field positions (SQ_LSB=0, COLOR_LSB=4).
  - State encoding localparams IDLE/SHOW/GAP.
- One natural sub-module: frame_counter (clear, frame_tick enable, terminal-count compare against a runtime limit), instanced once and reused across states.
- Pattern memory is an inline register array.

Test Plan:
- Setup for the timing scenarios: DWELL_FRAMES=2, GAP_FRAMES=1.
- Basic playback: write mem[0]={3'b100,4'b0001}, mem[1]={3'b010,4'b1000}; len=2, loop=0, start; frame_tick every 10 cycles -> squares=0001/color=100 for 2 ticks, 0000 for 1 tick, 1000/color=010 for 2 ticks, 0000 for 1 tick. Then busy=0 and done pulses once.
- Loop: same pattern with loop=1 -> after step 1's gap, step_idx=0 and squares=0001; no done pulse. Deassert loop mid-run -> done after the following step 1 gap.
- Zero gap (GAP_FRAMES=0), len=3 -> squares change directly between entries on consecutive dwell boundaries; never 0 while busy.
- abort during step 1 SHOW -> next cycle squares=0, busy=0, done=0, step_idx=0. Simultaneous start+abort while busy -> IDLE.
- Edge inputs:
  - len=0 start -> busy stays 0, no done.
  - len=15 with STEPS=8 -> exactly 8 steps played.
  - start during busy -> no restart.
  - frame_tick coincident with start -> first step still lasts the full DWELL_FRAMES ticks.
- Reset mid-GAP -> all outputs 0 next cycle. Memory rewritten during SHOW of step 0 -> new value visible on the next loop pass only.
